// File: rtl/ram_controller_pkg.sv
// Shared encodings for the RAM controller: access direction, access size,
// FSM states and the latency-counter width.
package ram_controller_pkg;

  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  // Wide enough for the largest legal latency count (LATENCY-1 = 14).
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/ram_array.sv
// Byte-addressed storage. Four combinational read ports return the four
// bytes of the aligned word, assembled big-endian. One synchronous write
// port takes per-byte enables: be_i[k] writes the byte at word offset k from
// wdata_i[31-8k -: 8].
module ram_array #(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rbase;
  logic [AW-1:0] wbase;

  assign rbase = {raddr_i[AW-1:2], 2'b00};
  assign wbase = {waddr_i[AW-1:2], 2'b00};

  // Four read ports: offset 0 lands in bits 31:24 (big-endian).
  assign rdata_o = {mem_q[rbase],
                    mem_q[rbase | AW'(1)],
                    mem_q[rbase | AW'(2)],
                    mem_q[rbase | AW'(3)]};

  // Byte-enabled write, one cycle.
  // NOTE: storage arrays get no reset; contents must survive reset and a
  // reset loop over every entry would not map onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[wbase | AW'(i)] <= wdata_i[31-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/ram_controller.sv
// Memory controller with a fixed-latency, four-phase MOC handshake.
// A request is captured in IDLE, counted down in BUSY, performed on the
// last BUSY edge, and acknowledged in ACK until memEnable drops.
module ram_controller
  import ram_controller_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memEnable,
  input  logic        RW,
  input  logic        size,
  input  logic        unSign,
  input  logic [31:0] address,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        MOC,
  output logic        alignErr
);

  localparam int AW = $clog2(DEPTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               rw_q, rw_d;
  logic               size_q, size_d;
  logic               unsign_q, unsign_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        dout_q, dout_d;
  logic               aerr_q, aerr_d;

  logic               capture;
  logic               done;
  logic               ack_exit;
  logic               misalign;
  logic               mem_we;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic [7:0]         rd_byte;
  logic [31:0]        rd_value;

  // Upper address bits are deliberately dropped (memory wraps).
  logic unused_addr;
  assign unused_addr = ^address[31:AW];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: IDLE -> BUSY -> ACK -> IDLE.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (memEnable)      state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0)    state_d = ST_ACK;
      ST_ACK:  if (!memEnable)     state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath strobes.
  always_comb begin
    MOC      = (state_q == ST_ACK);
    alignErr = aerr_q;
    dataOut  = dout_q;
    capture  = (state_q == ST_IDLE) && memEnable;
    done     = (state_q == ST_BUSY) && (cnt_q == '0);
    ack_exit = (state_q == ST_ACK) && !memEnable;
  end

  assign misalign = (size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00);

  // Write path: a byte write replicates the byte so any lane can take it.
  assign mem_we    = done && (rw_q == RW_WRITE) && !misalign;
  assign mem_be    = (size_q == SIZE_WORD) ? 4'b1111 : (4'b0001 << addr_q[1:0]);
  assign mem_wdata = (size_q == SIZE_WORD) ? wdata_q : {4{wdata_q[7:0]}};

  // Byte read lane select and extension.
  always_comb begin
    rd_byte = 8'h00;
    unique case (addr_q[1:0])
      2'd0: rd_byte = mem_rdata[31:24];
      2'd1: rd_byte = mem_rdata[23:16];
      2'd2: rd_byte = mem_rdata[15:8];
      2'd3: rd_byte = mem_rdata[7:0];
      default: rd_byte = 8'h00;
    endcase
    if (size_q == SIZE_WORD) rd_value = mem_rdata;
    else if (unsign_q)       rd_value = {24'h0, rd_byte};
    else                     rd_value = {{24{rd_byte[7]}}, rd_byte};
  end

  // Datapath next-state: capture, countdown, completion results.
  always_comb begin
    addr_d   = addr_q;
    rw_d     = rw_q;
    size_d   = size_q;
    unsign_d = unsign_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    aerr_d   = aerr_q;
    if (capture) begin
      addr_d   = address[AW-1:0];
      rw_d     = RW;
      size_d   = size;
      unsign_d = unSign;
      wdata_d  = dataIn;
      cnt_d    = CNT_W'(LATENCY - 1);
    end else if ((state_q == ST_BUSY) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (done) begin
      aerr_d = misalign;
      if (misalign)              dout_d = 32'h0;
      else if (rw_q == RW_READ)  dout_d = rd_value;
    end
    if (ack_exit) aerr_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      rw_q     <= RW_READ;
      size_q   <= SIZE_WORD;
      unsign_q <= 1'b0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      aerr_q   <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      unsign_q <= unsign_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      aerr_q   <= aerr_d;
    end
  end

  ram_array #(.DEPTH(DEPTH)) u_ram_array (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .waddr_i (addr_q),
    .wdata_i (mem_wdata),
    .raddr_i (addr_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_ram_controller.sv
// Scoreboard bench for ram_controller: requests push expected completions,
// a negedge monitor checks each MOC rise against the queue head.
module tb_ram_controller;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memEnable = 1'b0;
  logic        RW = 1'b0;
  logic        size = 1'b0;
  logic        unSign = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic        MOC;
  logic        alignErr;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          cap;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic moc_prev = 1'b0;

  ram_controller #(.LATENCY(LAT), .DEPTH(512)) dut (
    .clk       (clk),
    .reset     (reset),
    .memEnable (memEnable),
    .RW        (RW),
    .size      (size),
    .unSign    (unSign),
    .address   (address),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .MOC       (MOC),
    .alignErr  (alignErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every rising MOC consumes one expected completion.
  always @(negedge clk) begin
    if (MOC && !moc_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_moc", 32'(MOC), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dataOut", dataOut, e.d);
        check("alignErr", 32'(alignErr), 32'(e.e));
        check("latency", 32'(cyc - e.cap), 32'(LAT));
      end
    end
    moc_prev = MOC;
  end

  // One request; inputs are scrambled during BUSY to show they are ignored.
  task automatic req(input logic rw, input logic sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic exp_e,
                     input bit early_drop);
    int n;
    @(negedge clk);
    memEnable = 1'b1; RW = rw; size = sz; unSign = uns; address = a; dataIn = d;
    sb.push_back('{d: exp_d, e: exp_e, cap: cyc + 1});
    @(negedge clk);
    RW = ~rw; size = ~sz; unSign = ~uns; address = a ^ 32'h4; dataIn = ~d;
    if (early_drop) memEnable = 1'b0;
    n = 0;
    while (!MOC && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!MOC) check("moc_timeout", 32'(MOC), 32'd1);
    @(negedge clk);
    if (early_drop) begin
      check("early_drop_exit", 32'(MOC), 32'd0);
    end else begin
      check("ack_hold_moc", 32'(MOC), 32'd1);
      check("ack_hold_err", 32'(alignErr), 32'(exp_e));
      memEnable = 1'b0;
      @(negedge clk);
      check("moc_fall", 32'(MOC), 32'd0);
      check("err_clear", 32'(alignErr), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_moc", 32'(MOC), 32'd0);
    check("rst_err", 32'(alignErr), 32'd0);
    check("rst_dout", dataOut, 32'd0);
    reset = 1'b1;

    //   rw  sz  uns addr          data          exp dataOut   err early
    req(1'b1, 1'b0, 1'b0, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0);
    req(1'b0, 1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    req(1'b0, 1'b1, 1'b0, 32'h11,  32'h0,        32'hFFFFFFAD, 1'b0, 1'b0);
    req(1'b0, 1'b1, 1'b1, 32'h11,  32'h0,        32'h000000AD, 1'b0, 1'b0);
    req(1'b1, 1'b1, 1'b0, 32'h13,  32'hAABBCC12, 32'h000000AD, 1'b0, 1'b0);
    req(1'b0, 1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBE12, 1'b0, 1'b0);
    req(1'b0, 1'b1, 1'b0, 32'h13,  32'h0,        32'h00000012, 1'b0, 1'b0);
    req(1'b0, 1'b1, 1'b0, 32'h10,  32'h0,        32'hFFFFFFDE, 1'b0, 1'b0);
    req(1'b1, 1'b0, 1'b0, 32'h20,  32'hCAFEF00D, 32'hFFFFFFDE, 1'b0, 1'b0);
    req(1'b0, 1'b0, 1'b0, 32'h22,  32'h0,        32'h00000000, 1'b1, 1'b0);
    req(1'b1, 1'b0, 1'b0, 32'h22,  32'h12345678, 32'h00000000, 1'b1, 1'b0);
    req(1'b0, 1'b0, 1'b0, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0, 1'b0);
    req(1'b1, 1'b0, 1'b0, 32'h204, 32'h11223344, 32'hCAFEF00D, 1'b0, 1'b0);
    req(1'b0, 1'b0, 1'b0, 32'h004, 32'h0,        32'h11223344, 1'b0, 1'b0);
    req(1'b0, 1'b0, 1'b0, 32'h20,  32'h0,        32'hCAFEF00D, 1'b0, 1'b1);
    req(1'b1, 1'b0, 1'b0, 32'h30,  32'h55667788, 32'hCAFEF00D, 1'b0, 1'b0);

    // Reset one cycle into a write BUSY: no completion, no write.
    @(negedge clk);
    memEnable = 1'b1; RW = 1'b1; size = 1'b0; address = 32'h30; dataIn = 32'hFFFFFFFF;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midbusy_rst_moc", 32'(MOC), 32'd0);
    check("midbusy_rst_err", 32'(alignErr), 32'd0);
    check("midbusy_rst_dout", dataOut, 32'd0);
    memEnable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    req(1'b0, 1'b0, 1'b0, 32'h30,  32'h0,        32'h55667788, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
